// File: rtl/alu_issue_stage.sv
// ALU issue stage: single-entry pipeline register between decode and EX.
// Forwards MEM/WB results into rs1/rs2, selects operands, masks shift amounts.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   in_valid_i / in_ready_o         decode-side handshake
//   rs1/rs2/pc/imm, sels, alu_op    decoded instruction payload
//   rs1/rs2/rd addr, rd_wren_i      register specifiers
//   mem_rd_*, wb_rd_*, wb_data_i    forwarding candidates
//   flush_i                         kill held and incoming instruction
//   out_valid_o / out_ready_i       EX-side handshake
//   operand_a/b, alu_op, rd_*       registered ALU inputs
module alu_issue_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic        op_a_sel_i,
  input  logic        op_b_sel_i,
  input  logic [3:0]  alu_op_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_wren_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_rd_wren_i,
  input  logic [31:0] mem_rd_data_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_rd_wren_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [3:0]  alu_op_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wren_o
);

  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_wren;

  logic        w_capture;
  logic        w_rs1_mem;
  logic        w_rs1_wb;
  logic        w_rs2_mem;
  logic        w_rs2_wb;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_a;
  logic [31:0] w_b_sel;
  logic [31:0] w_b;
  logic        w_shift;

  assign in_ready_o = !r_valid | out_ready_i;
  assign w_capture  = in_valid_i & in_ready_o;

  // x0 is hardwired zero, so it never matches a producer.
  assign w_rs1_mem = FWD_EN & mem_rd_wren_i
                   & (mem_rd_addr_i == rs1_addr_i)
                   & (rs1_addr_i != 5'd0);
  assign w_rs1_wb  = FWD_EN & wb_rd_wren_i
                   & (wb_rd_addr_i == rs1_addr_i)
                   & (rs1_addr_i != 5'd0);
  assign w_rs2_mem = FWD_EN & mem_rd_wren_i
                   & (mem_rd_addr_i == rs2_addr_i)
                   & (rs2_addr_i != 5'd0);
  assign w_rs2_wb  = FWD_EN & wb_rd_wren_i
                   & (wb_rd_addr_i == rs2_addr_i)
                   & (rs2_addr_i != 5'd0);

  // MEM is younger than WB, so it wins.
  assign w_rs1 = w_rs1_mem ? mem_rd_data_i :
                 w_rs1_wb  ? wb_data_i     : rs1_data_i;
  assign w_rs2 = w_rs2_mem ? mem_rd_data_i :
                 w_rs2_wb  ? wb_data_i     : rs2_data_i;

  assign w_a     = op_a_sel_i ? pc_i  : w_rs1;
  assign w_b_sel = op_b_sel_i ? imm_i : w_rs2;

  always_comb begin
    w_shift = 1'b0;
    unique case (alu_op_i)
      4'b0001,
      4'b0101,
      4'b1101: w_shift = 1'b1;
      default: w_shift = 1'b0;
    endcase
  end

  assign w_b = w_shift ? {27'd0, w_b_sel[4:0]} : w_b_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 4'd0;
      r_rd    <= 5'd0;
      r_wren  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_wren  <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_op    <= alu_op_i;
      r_rd    <= rd_addr_i;
      r_wren  <= rd_wren_i & (rd_addr_i != 5'd0);
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign operand_a_o = r_a;
  assign operand_b_o = r_b;
  assign alu_op_o    = r_op;
  assign rd_addr_o   = r_rd;
  assign rd_wren_o   = r_wren;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] rs1_d, rs2_d, pc, imm;
  logic        a_sel, b_sel;
  logic [3:0]  op;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic        rd_w;
  logic [4:0]  m_a;
  logic        m_w;
  logic [31:0] m_d;
  logic [4:0]  w_a;
  logic        w_w;
  logic [31:0] w_d;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] opa, opb;
  logic [3:0]  op_o;
  logic [4:0]  rd_o;
  logic        rdw_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.FWD_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs1_data_i(rs1_d), .rs2_data_i(rs2_d),
    .pc_i(pc), .imm_i(imm),
    .op_a_sel_i(a_sel), .op_b_sel_i(b_sel),
    .alu_op_i(op),
    .rs1_addr_i(rs1_a), .rs2_addr_i(rs2_a),
    .rd_addr_i(rd_a), .rd_wren_i(rd_w),
    .mem_rd_addr_i(m_a), .mem_rd_wren_i(m_w),
    .mem_rd_data_i(m_d),
    .wb_rd_addr_i(w_a), .wb_rd_wren_i(w_w),
    .wb_data_i(w_d),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .operand_a_o(opa), .operand_b_o(opb),
    .alu_op_o(op_o), .rd_addr_o(rd_o),
    .rd_wren_o(rdw_o)
  );

  // model state: the one instruction the stage should be holding
  logic        e_valid;
  logic [31:0] e_a, e_b;
  logic [3:0]  e_op;
  logic [4:0]  e_rd;
  logic        e_wren;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src(logic [4:0] a, logic [31:0] d);
    if (a == 0) return d;
    if (m_w && m_a == a) return m_d;
    if (w_w && w_a == a) return w_d;
    return d;
  endfunction

  task automatic model_reset();
    e_valid = 0; e_a = 0; e_b = 0;
    e_op = 0; e_rd = 0; e_wren = 0;
  endtask

  task automatic cmp_all(string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".a"}, opa, e_a);
    chk({tag, ".b"}, opb, e_b);
    chk({tag, ".op"}, 32'(op_o), 32'(e_op));
    chk({tag, ".rd"}, 32'(rd_o), 32'(e_rd));
    chk({tag, ".wren"}, 32'(rdw_o), 32'(e_wren));
  endtask

  // one clock: predict from current inputs, clock, then compare
  task automatic step(string tag);
    logic        n_valid, n_wren;
    logic [31:0] n_a, n_b, bb;
    logic [3:0]  n_op;
    logic [4:0]  n_rd;
    n_valid = e_valid; n_a = e_a; n_b = e_b;
    n_op = e_op; n_rd = e_rd; n_wren = e_wren;
    if (flush) begin
      n_valid = 0;
      n_wren  = 0;
    end else if (in_valid && (!e_valid || out_ready)) begin
      n_valid = 1;
      n_a = a_sel ? pc : src(rs1_a, rs1_d);
      bb  = b_sel ? imm : src(rs2_a, rs2_d);
      if (op == 4'd1 || op == 4'd5 || op == 4'd13)
        bb = bb % 32;
      n_b = bb;
      n_op = op;
      n_rd = rd_a;
      n_wren = rd_w && rd_a != 0;
    end else if (out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    e_valid = n_valid; e_a = n_a; e_b = n_b;
    e_op = n_op; e_rd = n_rd; e_wren = n_wren;
    cmp_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1_d = 0; rs2_d = 0; pc = 0; imm = 0;
    a_sel = 0; b_sel = 0; op = 0; rs1_a = 0; rs2_a = 0;
    rd_a = 0; rd_w = 0; m_a = 0; m_w = 0; m_d = 0;
    w_a = 0; w_w = 0; w_d = 0; flush = 0; out_ready = 1;
  endtask

  typedef struct {
    logic [4:0]  rs1a, rs2a, rd, ma, wa;
    logic [31:0] rs1d, rs2d, pc, imm, md, wd;
    logic        asel, bsel, wren, mw, ww;
    logic [3:0]  op;
    logic [31:0] ea, eb;
    logic        ewren;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{rs1a:5, rs1d:10, rs2a:6, rs2d:3, rd:1, wren:1,
                ea:10, eb:3, ewren:1, default:'0};
    vecs[1] = '{rs1a:7, rs1d:'h1111, rs2a:8, rs2d:'h22,
                ma:7, mw:1, md:'hAAAA, wa:7, ww:1, wd:'hBBBB,
                rd:2, wren:1,
                ea:'hAAAA, eb:'h22, ewren:1, default:'0};
    vecs[2] = '{rs1a:7, rs1d:'h1111, rs2a:8, rs2d:'h22,
                ma:7, mw:0, md:'hAAAA, wa:7, ww:1, wd:'hBBBB,
                rd:3, wren:1,
                ea:'hBBBB, eb:'h22, ewren:1, default:'0};
    vecs[3] = '{rs1a:0, rs1d:'h1234, rs2a:0, rs2d:'h55,
                ma:0, mw:1, md:'hAAAA, wa:0, ww:1, wd:'hBBBB,
                rd:4, wren:1,
                ea:'h1234, eb:'h55, ewren:1, default:'0};
    vecs[4] = '{rs1a:1, rs1d:9, op:4'b0101, bsel:1,
                imm:'hFFFF_FFE3, rd:5, wren:1,
                ea:9, eb:3, ewren:1, default:'0};
    vecs[5] = '{rs1a:1, rs1d:9, op:4'b0000, bsel:1,
                imm:'hFFFF_FFE3, rd:5, wren:1,
                ea:9, eb:'hFFFF_FFE3, ewren:1, default:'0};
    vecs[6] = '{asel:1, pc:'h100, rs2a:2, rs2d:'h47,
                op:4'b1101, rd:0, wren:1,
                ea:'h100, eb:7, ewren:0, default:'0};
    vecs[7] = '{rs1a:9, rs1d:1, rs2a:3, rs2d:'h10,
                ma:4, mw:1, md:'hDEAD, wa:3, ww:1, wd:'hCAFE,
                op:4'b0010, rd:6, wren:1,
                ea:1, eb:'hCAFE, ewren:1, default:'0};
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #2;
    cmp_all("reset");
    @(negedge clk);
    rst_n = 1;

    // directed table, back to back at full rate
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      rs1_a = vecs[i].rs1a; rs1_d = vecs[i].rs1d;
      rs2_a = vecs[i].rs2a; rs2_d = vecs[i].rs2d;
      pc = vecs[i].pc; imm = vecs[i].imm;
      a_sel = vecs[i].asel; b_sel = vecs[i].bsel;
      op = vecs[i].op; rd_a = vecs[i].rd; rd_w = vecs[i].wren;
      m_a = vecs[i].ma; m_w = vecs[i].mw; m_d = vecs[i].md;
      w_a = vecs[i].wa; w_w = vecs[i].ww; w_d = vecs[i].wd;
      out_ready = 1;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d.tbl_a", i), opa, vecs[i].ea);
      chk($sformatf("vec%0d.tbl_b", i), opb, vecs[i].eb);
      chk($sformatf("vec%0d.tbl_op", i), 32'(op_o),
          32'(vecs[i].op));
      chk($sformatf("vec%0d.tbl_wren", i), 32'(rdw_o),
          32'(vecs[i].ewren));
    end
    idle_inputs();
    step("drain");
    chk("drain.tbl_valid", 32'(out_valid), 0);

    // stall: X held while Y waits, then both move with no bubble
    in_valid = 1; rs1_a = 1; rs1_d = 32'h0000_0A0A;
    rd_a = 7; rd_w = 1;
    step("stallX");
    rs1_d = 32'h0000_0B0B; rd_a = 8; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 0);
      step($sformatf("stall%0d", k));
      chk($sformatf("stall%0d.held_a", k), opa, 32'h0A0A);
    end
    out_ready = 1;
    #1;
    chk("release.in_ready", 32'(in_ready), 1);
    step("release");
    chk("release.y_valid", 32'(out_valid), 1);
    chk("release.y_a", opa, 32'h0B0B);
    in_valid = 0;
    step("release_drain");

    // flush with a held instruction and a new one offered
    in_valid = 1; rs1_d = 32'h77; rd_a = 9; rd_w = 1;
    out_ready = 0;
    step("pre_flush");
    flush = 1;
    step("flush");
    chk("flush.tbl_valid", 32'(out_valid), 0);
    chk("flush.tbl_wren", 32'(rdw_o), 0);
    flush = 0;
    in_valid = 0;
    step("post_flush");

    // async reset in the middle of a stall
    in_valid = 1; rs1_d = 32'h99; rd_a = 10; out_ready = 0;
    step("pre_rst");
    step("pre_rst_stall");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    cmp_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    rs1_d = 32'h5A5A;
    step("first_after_rst");
    chk("first_after_rst.tbl_a", opa, 32'h5A5A);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      rs1_a = 5'($urandom_range(0, 3));
      rs2_a = 5'($urandom_range(0, 3));
      rd_a  = 5'($urandom_range(0, 3));
      rd_w  = 1'($urandom);
      rs1_d = $urandom; rs2_d = $urandom;
      pc = $urandom; imm = $urandom;
      a_sel = 1'($urandom); b_sel = 1'($urandom);
      op = 4'($urandom);
      m_a = 5'($urandom_range(0, 3)); m_w = 1'($urandom);
      m_d = $urandom;
      w_a = 5'($urandom_range(0, 3)); w_w = 1'($urandom);
      w_d = $urandom;
      #1;
      chk("rand.in_ready", 32'(in_ready),
          32'(!e_valid || out_ready));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, enables MEM/WB operand forwarding; when 0, the register-file data passes through unmodified.
REQ-002 clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid_i  in  1 / in_ready_o  out  1  upstream (decode) handshake.
REQ-005 rs1_data_i, rs2_data_i, pc_i, imm_i  in  32 each  register-file operands, instruction PC, sign-extended immediate.
REQ-006 op_a_sel_i  in  1  (0 = rs1, 1 = pc); op_b_sel_i  in  1  (0 = rs2, 1 = imm).
REQ-007 alu_op_i  in  4  ALU operation code in the team ALU encoding; rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each; rd_wren_i  in  1.
REQ-008 mem_rd_addr_i  in  5, mem_rd_wren_i  in  1, mem_rd_data_i  in  32  MEM-stage writeback candidate.
REQ-009 wb_rd_addr_i  in  5, wb_rd_wren_i  in  1, wb_data_i  in  32  WB-stage writeback candidate.
REQ-010 flush_i  in  1  kill the held instruction and any instruction being captured.
REQ-011 out_valid_o  out  1 / out_ready_i  in  1  downstream (ALU/EX) handshake.
REQ-012 operand_a_o, operand_b_o  out  32 each; alu_op_o  out  4; rd_addr_o  out  5; rd_wren_o  out  1  registered ALU inputs.

Function
REQ-013 Single-entry pipeline register; in_ready_o = !out_valid_o | out_ready_i, combinational.
REQ-014 Transfer in: in_valid_i & in_ready_o at the rising edge captures all payload inputs and sets out_valid_o next cycle; latency 1 cycle from accept to out_valid_o.
REQ-015 Transfer out: out_valid_o & out_ready_i; if there is no simultaneous capture, out_valid_o clears at that edge.
REQ-016 Simultaneous transfer out and capture in the same cycle replaces the entry; out_valid_o stays 1 and full throughput is one instruction per cycle.
REQ-017 Stall: out_valid_o=1 & out_ready_i=0 holds every output stable and in_ready_o=0.
REQ-018 Forwarding applies to rs1 and rs2 independently before operand select, evaluated at capture time from the current-cycle MEM/WB inputs.
REQ-019 Forwarding priority: MEM match (mem_rd_wren_i & mem_rd_addr_i == rsX_addr_i & rsX_addr_i != 0) over WB match (same rule with wb_*) over register-file data.
REQ-020 Register x0 is never forwarded; a source with rsX_addr_i = 0 uses rsX_data_i unchanged.
REQ-021 Operand A is the forwarded rs1 or pc_i per op_a_sel_i; operand B is the forwarded rs2 or imm_i per op_b_sel_i.
REQ-022 Shift masking: for alu_op_i in {4'b0001 SLL, 4'b0101 SRL, 4'b1101 SRA}, operand_b_o = {27'b0, B[4:0]}; other opcodes pass B unmodified.
REQ-023 A captured rd_addr_i = 0 forces rd_wren_o = 0.
REQ-024 flush_i=1 at an edge clears out_valid_o and rd_wren_o, blocks capture even if in_valid_i=1, and overrides every other transfer rule.
REQ-025 When out_valid_o=0, the payload outputs hold their last values; consumers qualify them with out_valid_o.

Reset
REQ-026 While rst_ni=0: out_valid_o=0, rd_wren_o=0, operand_a_o=0, operand_b_o=0, alu_op_o=4'b0000, rd_addr_o=0, asynchronously.
REQ-027 Reset asserted mid-stall discards the held instruction; after rst_ni rises, the first capture is allowed on the first rising edge.

Verification
REQ-028 rs1=5 data 10, rs2=6 data 3, sel=0/0, alu_op=0000, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, A=10, B=3, alu_op=0000; following cycle out_valid=0.
REQ-029 rs1_addr=7 with mem_rd_addr=7/wren=1/data=0xAAAA and wb_rd_addr=7/wren=1/data=0xBBBB -> A=0xAAAA; with mem_rd_wren=0 -> A=0xBBBB; with rs1_addr=0 and both matching 0 -> A=rs1_data_i.
REQ-030 alu_op=0101, op_b_sel=1, imm=0xFFFF_FFE3 -> operand_b_o=0x0000_0003; alu_op=0000 with the same imm -> B=0xFFFF_FFE3.
REQ-031 Capture instruction X, hold out_ready=0 for 3 cycles with in_valid=1 carrying Y -> X is stable and in_ready=0; out_ready=1 -> X and Y move in the same cycle and Y appears next cycle with no bubble.
REQ-032 flush_i=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and rd_wren_o=0; rst_ni low mid-stall -> all outputs are 0 immediately, without waiting for a clock edge.
